// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with a 32-bit free-running counter.
// Each channel emits a one-cycle tick per period and a toggle- or duty-mode enable waveform.
module clk_div_multi #(
    parameter int CH_W  = 2,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   sync,
    input  logic                   wr_en,
    input  logic [CH_W-1:0]        wr_ch,
    input  logic [WIDTH-1:0]       wr_div,
    input  logic                   wr_mode,
    output logic [(2**CH_W)-1:0]   tick,
    output logic [(2**CH_W)-1:0]   clk_out,
    output logic [31:0]            cnt_free
);

    localparam int NCH = 2**CH_W;

    logic [31:0] cnt_free_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_free_q <= '0;
        end else begin
            cnt_free_q <= cnt_free_q + 32'd1;
        end
    end

    assign cnt_free = cnt_free_q;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [WIDTH-1:0] div_q, div_d;
            logic [WIDTH-1:0] cnt_q, cnt_d;
            logic             mode_q, mode_d;
            logic             clk_q, clk_d;
            logic             wr_hit;
            logic             wrap;

            assign wr_hit = wr_en && (wr_ch == CH_W'(gi));
            assign wrap   = (cnt_q == div_q);

            // A write to this channel takes priority over a global sync restart.
            always_comb begin
                div_d  = div_q;
                mode_d = mode_q;
                cnt_d  = cnt_q;
                clk_d  = clk_q;
                if (wr_hit) begin
                    div_d  = wr_div;
                    mode_d = wr_mode;
                    cnt_d  = '0;
                    clk_d  = wr_mode && (wr_div != '0);
                end else if (sync) begin
                    cnt_d = '0;
                    clk_d = mode_q && (div_q != '0);
                end else if (div_q == '0) begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                end else if (en) begin
                    cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
                    // Duty mode tracks the next count so the output stays aligned with cnt.
                    clk_d = mode_q ? (cnt_d <= (div_q >> 1)) : (clk_q ^ wrap);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    div_q  <= '0;
                    mode_q <= 1'b0;
                    cnt_q  <= '0;
                    clk_q  <= 1'b0;
                end else begin
                    div_q  <= div_d;
                    mode_q <= mode_d;
                    cnt_q  <= cnt_d;
                    clk_q  <= clk_d;
                end
            end

            assign tick[gi]    = en && (div_q != '0) && wrap;
            assign clk_out[gi] = clk_q;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised self-checking bench for clk_div_multi against a phase-count reference model.
// The model tracks elapsed enabled cycles per channel and derives outputs arithmetically.
module tb_clk_div_multi;

    localparam int CH_W  = 2;
    localparam int WIDTH = 16;
    localparam int NCH   = 2**CH_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             sync = 1'b0;
    logic             wr_en = 1'b0;
    logic [CH_W-1:0]  wr_ch = '0;
    logic [WIDTH-1:0] wr_div = '0;
    logic             wr_mode = 1'b0;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   clk_out;
    logic [31:0]      cnt_free;

    int checks = 0;
    int errors = 0;

    int          m_div  [NCH];
    logic        m_mode [NCH];
    int          m_ph   [NCH];
    logic [31:0] m_free;

    clk_div_multi #(.CH_W(CH_W), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_mode (wr_mode),
        .tick    (tick),
        .clk_out (clk_out),
        .cnt_free(cnt_free)
    );

    always #5 clk = ~clk;

    function automatic logic [NCH-1:0] m_tick_f();
        logic [NCH-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++)
            if (en && m_div[i] != 0 && (m_ph[i] % (m_div[i] + 1)) == m_div[i]) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [NCH-1:0] m_clk_f();
        logic [NCH-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m_div[i] == 0)   r[i] = 1'b0;
            else if (m_mode[i])  r[i] = (m_ph[i] % (m_div[i] + 1)) <= (m_div[i] / 2);
            else                 r[i] = ((m_ph[i] / (m_div[i] + 1)) % 2) == 1;
        end
        return r;
    endfunction

    task automatic model_clear();
        m_free = '0;
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = 0; m_mode[i] = 1'b0; m_ph[i] = 0;
        end
    endtask

    task automatic drive(input logic e, input logic s, input logic w,
                         input int ch, input int d, input logic m);
        en = e; sync = s; wr_en = w;
        wr_ch = ch[CH_W-1:0]; wr_div = d[WIDTH-1:0]; wr_mode = m;
        #1;
    endtask

    // One rising edge: update the model from the inputs seen at that edge, return at negedge.
    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            m_free = m_free + 32'd1;
            for (int i = 0; i < NCH; i++) begin
                if (wr_en && int'(wr_ch) == i) begin
                    m_div[i] = int'(wr_div); m_mode[i] = wr_mode; m_ph[i] = 0;
                end else if (sync) begin
                    m_ph[i] = 0;
                end else if (en && m_div[i] != 0) begin
                    m_ph[i]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_clear();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (tick !== '0 || clk_out !== '0 || cnt_free !== 32'd0) begin
            errors++;
            $display("FAIL reset_state tick=%b clk_out=%b cnt_free=%0d exp 0/0/0", tick, clk_out, cnt_free);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
            advance();
        end
        checks++;
        if (cnt_free !== 32'd10) begin
            errors++;
            $display("FAIL reset_free10 cnt_free=%0d exp=10", cnt_free);
        end
        checks++;
        if (tick !== '0 || clk_out !== '0) begin
            errors++;
            $display("FAIL reset_idle tick=%b clk_out=%b exp 0/0", tick, clk_out);
        end
    endtask

    task automatic test_toggle();
        int first_tick;
        drive(1'b1, 1'b0, 1'b1, 0, 3, 1'b0);
        advance();
        first_tick = -1;
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
            if (tick[0] && first_tick < 0) first_tick = c;
            checks++;
            if (tick !== m_tick_f() || clk_out !== m_clk_f()) begin
                errors++;
                $display("FAIL toggle c=%0d tick=%b exp=%b clk_out=%b exp=%b", c, tick, m_tick_f(), clk_out, m_clk_f());
            end
            advance();
        end
        checks++;
        if (first_tick != 3) begin
            errors++;
            $display("FAIL toggle_first_tick got=%0d exp=3", first_tick);
        end
    endtask

    task automatic test_duty();
        drive(1'b1, 1'b0, 1'b1, 1, 2, 1'b1);
        advance();
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
            checks++;
            if (tick !== m_tick_f() || clk_out !== m_clk_f()) begin
                errors++;
                $display("FAIL duty c=%0d tick=%b exp=%b clk_out=%b exp=%b", c, tick, m_tick_f(), clk_out, m_clk_f());
            end
            advance();
        end
    endtask

    task automatic test_en_hold();
        for (int c = 0; c < 8 && (m_ph[0] % 4) != 1; c++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
            advance();
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
            checks++;
            if (tick !== '0 || clk_out !== m_clk_f()) begin
                errors++;
                $display("FAIL en_hold c=%0d tick=%b exp=0 clk_out=%b exp=%b", c, tick, clk_out, m_clk_f());
            end
            advance();
        end
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
            checks++;
            if (tick[0] !== (c == 2)) begin
                errors++;
                $display("FAIL en_resume c=%0d tick0=%b exp=%b", c, tick[0], (c == 2));
            end
            checks++;
            if (tick !== m_tick_f() || clk_out !== m_clk_f()) begin
                errors++;
                $display("FAIL en_resume_all c=%0d tick=%b exp=%b clk_out=%b exp=%b", c, tick, m_tick_f(), clk_out, m_clk_f());
            end
            advance();
        end
    endtask

    task automatic test_sync_write();
        drive(1'b1, 1'b0, 1'b1, 2, 5, 1'b0);
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
            advance();
        end
        drive(1'b1, 1'b1, 1'b1, 2, 1, 1'b1);
        advance();
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
            checks++;
            if (tick !== m_tick_f() || clk_out !== m_clk_f()) begin
                errors++;
                $display("FAIL sync_write c=%0d tick=%b exp=%b clk_out=%b exp=%b", c, tick, m_tick_f(), clk_out, m_clk_f());
            end
            if (c == 3) begin
                checks++;
                if (tick[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL sync_ch0_tick tick0=%b exp=1", tick[0]);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        for (int ch = 0; ch < NCH; ch++) begin
            drive(1'b1, 1'b0, 1'b1, ch, int'($urandom_range(1, 6)), 1'($urandom));
            checks++;
            if (tick !== m_tick_f() || clk_out !== m_clk_f()) begin
                errors++;
                $display("FAIL b2b_write ch=%0d tick=%b exp=%b clk_out=%b exp=%b", ch, tick, m_tick_f(), clk_out, m_clk_f());
            end
            advance();
        end
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
            checks++;
            if (tick !== m_tick_f() || clk_out !== m_clk_f()) begin
                errors++;
                $display("FAIL b2b_run c=%0d tick=%b exp=%b clk_out=%b exp=%b", c, tick, m_tick_f(), clk_out, m_clk_f());
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int d;
            d = ($urandom % 10 == 0) ? int'($urandom_range(8, 40)) : int'($urandom_range(0, 7));
            drive(1'($urandom % 8 != 0), 1'($urandom % 20 == 0), 1'($urandom % 6 == 0),
                  int'($urandom % NCH), d, 1'($urandom));
            checks++;
            if (tick !== m_tick_f() || clk_out !== m_clk_f() || cnt_free !== m_free) begin
                errors++;
                $display("FAIL random c=%0d tick=%b exp=%b clk_out=%b exp=%b free=%0d exp=%0d",
                         c, tick, m_tick_f(), clk_out, m_clk_f(), cnt_free, m_free);
            end
            advance();
        end
    endtask

    task automatic test_disable_reset();
        drive(1'b1, 1'b0, 1'b1, 0, 3, 1'b0);
        advance();
        drive(1'b1, 1'b0, 1'b1, 3, 4, 1'b1);
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
            advance();
        end
        drive(1'b1, 1'b0, 1'b1, 3, 0, 1'b1);
        advance();
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        checks++;
        if (tick[3] !== 1'b0 || clk_out[3] !== 1'b0 || clk_out !== m_clk_f()) begin
            errors++;
            $display("FAIL disable_ch3 tick3=%b clk_out=%b exp=%b", tick[3], clk_out, m_clk_f());
        end
        advance();
        // Assert reset mid-period, away from any clock edge.
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (tick !== '0 || clk_out !== '0 || cnt_free !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid tick=%b clk_out=%b cnt_free=%0d exp 0/0/0", tick, clk_out, cnt_free);
        end
        repeat (2) advance();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
            checks++;
            if (tick !== '0 || clk_out !== '0 || cnt_free !== m_free) begin
                errors++;
                $display("FAIL post_rst c=%0d tick=%b clk_out=%b free=%0d exp=%0d", c, tick, clk_out, cnt_free, m_free);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_duty();
        test_en_hold();
        test_sync_write();
        test_back_to_back();
        test_random();
        test_disable_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised successor to the team's free-running clock-divider counter.
- Provides NCH independent programmable divider channels, each producing a single-cycle tick and a divided clock-enable waveform in toggle or duty mode.
- Keeps a 32-bit free-running counter output so existing consumers of raw divider bits keep working.
- Sits between the board clock and display-scan, debounce and blink logic; divisors are written by the control FSM.

Parameters:
- CH_W, 2, channel-select width; NCH = 2**CH_W channels.
- WIDTH, 16, divisor/counter width per channel.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  global count enable.
- sync  in  1  synchronous restart of all channel counters.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  CH_W  channel index for write.
- wr_div  in  WIDTH  divisor value D; 0 disables the channel.
- wr_mode  in  1  0 = toggle mode, 1 = duty mode.
- tick  out  NCH  one-cycle pulse per channel period.
- clk_out  out  NCH  divided waveform per channel.
- cnt_free  out  32  free-running counter.

Behaviour:
Reset values:
- All registers cleared: D[i]=0, mode[i]=0, cnt[i]=0, clk_out=0, cnt_free=0.
- tick is therefore 0 while rst is high.

Free-running counter:
- cnt_free increments by 1 on every rising clk edge, independent of en, sync and wr_en.
- Wraps from 0xFFFFFFFF to 0.

Per-channel counter (channel i, D[i]!=0, en=1):
- cnt[i] counts 0,1,…,D[i], then returns to 0. Period = D[i]+1 cycles.
- tick[i] = en & (D[i]!=0) & (cnt[i]==D[i]). Combinational decode of registered state; high exactly one cycle per period.
- Toggle mode: clk_out[i] toggles on the edge where cnt[i] wraps D[i]->0. Output period = 2*(D[i]+1) cycles, 50% duty.
- Duty mode: clk_out[i] is registered and always equals (cnt[i] <= D[i]>>1).
  - D=1: 1 cycle high, 1 cycle low.
  - D=2: 2 high, 1 low.

Disabled channel (D[i]==0):
- cnt[i]=0, tick[i]=0, clk_out[i]=0, held.

en=0:
- All cnt[i] and clk_out hold their values; tick forced to 0.
- cnt_free still runs.

Write (wr_en=1 at an edge):
- D[wr_ch]<=wr_div, mode[wr_ch]<=wr_mode, cnt[wr_ch]<=0.
- clk_out[wr_ch] <= 1 if wr_mode=1 and wr_div!=0, else 0.
- Other channels are unaffected.
- A write applies even when en=0.
- First tick occurs wr_div cycles after the write edge (en held high).

sync=1 at an edge:
- Every channel: cnt<=0; clk_out<=(mode & D!=0).
- D and mode are unchanged.
- Applies regardless of en.

Simultaneous events:
- sync with wr_en: the write fully applies to wr_ch; sync applies to all other channels.
- sync/wr while the counter is at D: no tick is generated after the restart edge; the counter restarts from 0.

Reset mid-operation:
- Asynchronous clear to the reset values above.
- All channels are disabled until rewritten.

Width rules:
- cnt[i] is WIDTH bits; D max = 2**WIDTH-1, so cnt never overflows.
- wr_ch out of range is impossible, since NCH = 2**CH_W.

Test Plan:
1. Reset, then en=1 for 10 cycles -> cnt_free=10; tick=0 and clk_out=0 on all channels; force cnt_free=0xFFFFFFFF -> wraps to 0 next edge.
2. Write ch0 D=3 mode0, en=1 -> tick[0] high on cycles 3,7,11 after the write edge; clk_out[0] toggles every 4 cycles (period 8).
3. Write ch1 D=2 mode1 -> clk_out[1] pattern 1,1,0 repeating; tick[1] coincides with the low cycle.
4. Ch0 running D=3, drop en for 5 cycles at cnt=1 -> cnt holds 1, no tick; resume -> next tick 2 cycles later.
5. Ch0 D=3 and ch2 D=5 running, assert sync with wr_en ch2 D=1 mode1 -> ch0 restarts at 0 (tick 3 cycles later); ch2 runs D=1 with clk_out 1,0 alternating.
6. Write ch3 D=0 while it is running, then assert rst mid-period on ch0 -> ch3 tick/clk_out go 0 immediately; after rst all outputs are 0 and cnt_free=0.
